// File: rtl/time_of_day_pkg.sv
// time_pkg: shared state/cursor types, field limits, digit helpers
// and the active-low 7-segment table used by time_of_day.
package time_pkg;

    typedef enum logic {RUN, EDIT} state_t;

    typedef enum logic [1:0] {HOUR, MIN, SEC} cursor_t;

    localparam logic [6:0] HOUR_MAX = 7'd23;
    localparam logic [6:0] MS_MAX   = 7'd59;

    // Entry d is the {dp,g..a} pattern for digit d, dp off.
    localparam logic [9:0][7:0] SEG7 = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [6:0] wrap_inc(
        input logic [6:0] v,
        input logic [6:0] max
    );
        return (v == max) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] wrap_dec(
        input logic [6:0] v,
        input logic [6:0] max
    );
        return (v == 7'd0) ? max : v - 7'd1;
    endfunction

    function automatic logic [3:0] tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

endpackage

// File: rtl/time_of_day_if.sv
// time_of_day_if: shared six-button pad plus mode select.
// master drives up/down/left/right/enter/esc/mode; slave receives them.
interface time_of_day_if;

    logic up;
    logic down;
    logic left;
    logic right;
    logic enter;
    logic esc;
    logic mode;

    modport master (
        output up, down, left, right, enter, esc, mode
    );

    modport slave (
        input up, down, left, right, enter, esc, mode
    );

endinterface

// File: rtl/time_of_day_seg7_digit.sv
// seg7_digit: one decimal digit to active-low {dp,g,f,e,d,c,b,a}.
// Ports: digit (0..9), dp (1 = light the point), seg (pattern).
module seg7_digit
    import time_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        if (digit <= 4'd9) begin
            seg = SEG7[digit];
        end
        seg[7] = ~dp;
    end

endmodule

// File: rtl/time_of_day.sv
// time_of_day: hh:mm:ss clock with button time-set and 6-digit 7-seg output.
// Ports: clk, rst_n (sync, active-low), pad (time_of_day_if.slave buttons),
//   carry_out (midnight pulse), out (6 digits, active-low), norm (1 = RUN),
//   hour/minute/second (live binary time).
// Build option BLINK_EN: blink the selected field instead of lighting its dp.
module time_of_day
    import time_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    time_of_day_if.slave pad,
    output logic         carry_out,
    output logic [47:0]  out,
    output logic         norm,
    output logic [6:0]   hour,
    output logic [6:0]   minute,
    output logic [6:0]   second
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nx;
    logic          tick;
    logic          commit;
    logic          carry_nx;

    state_t  state;
    state_t  state_nx;
    cursor_t cursor;
    cursor_t cursor_nx;

    logic [6:0] sh_h, sh_m, sh_s;
    logic [6:0] sh_h_nx, sh_m_nx, sh_s_nx;
    logic [6:0] h_nx, m_nx, s_nx;

    assign tick = (presc == P_LAST);

    // Edit FSM; only the highest-priority button is acted on.
    always_comb begin
        state_nx  = state;
        cursor_nx = cursor;
        sh_h_nx   = sh_h;
        sh_m_nx   = sh_m;
        sh_s_nx   = sh_s;
        commit    = 1'b0;
        unique case (state)
            RUN: begin
                if (pad.mode && !pad.esc && pad.enter) begin
                    state_nx  = EDIT;
                    cursor_nx = HOUR;
                    sh_h_nx   = hour;
                    sh_m_nx   = minute;
                    sh_s_nx   = second;
                end
            end
            EDIT: begin
                if (!pad.mode || pad.esc) begin
                    state_nx = RUN;
                end else if (pad.enter) begin
                    state_nx = RUN;
                    commit   = 1'b1;
                end else if (pad.up) begin
                    unique case (cursor)
                        HOUR:    sh_h_nx = wrap_inc(sh_h, HOUR_MAX);
                        MIN:     sh_m_nx = wrap_inc(sh_m, MS_MAX);
                        default: sh_s_nx = wrap_inc(sh_s, MS_MAX);
                    endcase
                end else if (pad.down) begin
                    unique case (cursor)
                        HOUR:    sh_h_nx = wrap_dec(sh_h, HOUR_MAX);
                        MIN:     sh_m_nx = wrap_dec(sh_m, MS_MAX);
                        default: sh_s_nx = wrap_dec(sh_s, MS_MAX);
                    endcase
                end else if (pad.left) begin
                    unique case (cursor)
                        HOUR:    cursor_nx = SEC;
                        MIN:     cursor_nx = HOUR;
                        default: cursor_nx = MIN;
                    endcase
                end else if (pad.right) begin
                    unique case (cursor)
                        HOUR:    cursor_nx = MIN;
                        MIN:     cursor_nx = SEC;
                        default: cursor_nx = HOUR;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= RUN;
            cursor <= HOUR;
            sh_h   <= '0;
            sh_m   <= '0;
            sh_s   <= '0;
        end else begin
            state  <= state_nx;
            cursor <= cursor_nx;
            sh_h   <= sh_h_nx;
            sh_m   <= sh_m_nx;
            sh_s   <= sh_s_nx;
        end
    end

    // Live time keeps running in EDIT; a commit restarts the second
    // and swallows a tick landing on the same cycle.
    always_comb begin
        h_nx     = hour;
        m_nx     = minute;
        s_nx     = second;
        carry_nx = 1'b0;
        presc_nx = tick ? '0 : presc + PW'(1);
        if (commit) begin
            h_nx     = sh_h;
            m_nx     = sh_m;
            s_nx     = sh_s;
            presc_nx = '0;
        end else if (tick) begin
            if (second == MS_MAX) begin
                s_nx = '0;
                if (minute == MS_MAX) begin
                    m_nx = '0;
                    if (hour == HOUR_MAX) begin
                        h_nx     = '0;
                        carry_nx = 1'b1;
                    end else begin
                        h_nx = hour + 7'd1;
                    end
                end else begin
                    m_nx = minute + 7'd1;
                end
            end else begin
                s_nx = second + 7'd1;
            end
        end
    end

    logic [6:0]  dh, dm, ds;
    logic [5:0]  sel;
    logic [5:0]  dp_on;
    logic [5:0]  blank;
    logic [3:0]  dig [6];
    logic [7:0]  seg [6];
    logic [47:0] out_nx;

    always_comb begin
        dh  = (state == EDIT) ? sh_h : hour;
        dm  = (state == EDIT) ? sh_m : minute;
        ds  = (state == EDIT) ? sh_s : second;
        sel = '0;
        if (state == EDIT) begin
            unique case (cursor)
                HOUR:    sel = 6'b110000;
                MIN:     sel = 6'b001100;
                default: sel = 6'b000011;
            endcase
        end
    end

`ifdef BLINK_EN
    localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);
    assign dp_on = '0;
    assign blank = (presc >= P_HALF) ? sel : '0;
`else
    assign dp_on = sel;
    assign blank = '0;
`endif

    assign dig[5] = tens(dh);
    assign dig[4] = ones(dh);
    assign dig[3] = tens(dm);
    assign dig[2] = ones(dm);
    assign dig[1] = tens(ds);
    assign dig[0] = ones(ds);

    for (genvar k = 0; k < 6; k++) begin : g_dig
        seg7_digit u_seg (
            .digit (dig[k]),
            .dp    (dp_on[k]),
            .seg   (seg[k])
        );
        assign out_nx[8*k +: 8] = blank[k] ? 8'hFF : seg[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc     <= '0;
            hour      <= '0;
            minute    <= '0;
            second    <= '0;
            carry_out <= 1'b0;
            norm      <= 1'b1;
            out       <= {6{8'hC0}};
        end else begin
            presc     <= presc_nx;
            hour      <= h_nx;
            minute    <= m_nx;
            second    <= s_nx;
            carry_out <= carry_nx;
            norm      <= (state_nx == RUN);
            out       <= out_nx;
        end
    end

endmodule

// File: tb/tb_time_of_day.sv
// tb_time_of_day: directed and random stimulus for time_of_day,
// checked every cycle against a seconds-of-day reference model.
module tb_time_of_day;

    localparam int HZ = 4;

    localparam logic [6:0] B_RIGHT = 7'h01;
    localparam logic [6:0] B_LEFT  = 7'h02;
    localparam logic [6:0] B_DOWN  = 7'h04;
    localparam logic [6:0] B_UP    = 7'h08;
    localparam logic [6:0] B_ENTER = 7'h10;
    localparam logic [6:0] B_ESC   = 7'h20;
    localparam logic [6:0] B_MODE  = 7'h40;

`ifdef BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        carry_out;
    logic        norm;
    logic [47:0] out;
    logic [6:0]  hour;
    logic [6:0]  minute;
    logic [6:0]  second;

    time_of_day_if pad ();

    time_of_day #(.CLK_HZ(HZ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pad       (pad),
        .carry_out (carry_out),
        .out       (out),
        .norm      (norm),
        .hour      (hour),
        .minute    (minute),
        .second    (second)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: live time as seconds of day.
    int          m_secs;
    int          m_pre;
    int          m_cur;
    int          m_sh [3];
    bit          m_edit;
    bit          m_carry;
    logic [47:0] m_out;

    int lim [3] = '{24, 60, 60};
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [47:0] disp(input int a, input int b,
                                         input int c, input bit ed,
                                         input int cur, input int pre);
        int v [3];
        logic [47:0] r;
        logic [7:0] p;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        r = '0;
        for (int f = 0; f < 3; f++) begin
            for (int t = 0; t < 2; t++) begin
                p = seg_tab[(t == 0) ? v[f] / 10 : v[f] % 10];
                if (ed && f == cur) begin
                    if (BLINK) begin
                        if (pre >= HZ / 2) p = 8'hFF;
                    end else begin
                        p[7] = 1'b0;
                    end
                end
                r[8*(5-2*f-t) +: 8] = p;
            end
        end
        return r;
    endfunction

    task automatic model_step(input bit r, input logic [6:0] b);
        bit tick;
        bit commit;
        if (r) begin
            m_secs  = 0;
            m_pre   = 0;
            m_cur   = 0;
            m_edit  = 0;
            m_carry = 0;
            m_sh    = '{0, 0, 0};
            m_out   = {6{8'hC0}};
            return;
        end
        if (m_edit)
            m_out = disp(m_sh[0], m_sh[1], m_sh[2], 1'b1, m_cur, m_pre);
        else
            m_out = disp(m_secs / 3600, (m_secs / 60) % 60, m_secs % 60,
                         1'b0, m_cur, m_pre);
        tick   = (m_pre == HZ - 1);
        commit = 0;
        if (!m_edit) begin
            if (b[6] && !b[5] && b[4]) begin
                m_edit   = 1;
                m_cur    = 0;
                m_sh[0]  = m_secs / 3600;
                m_sh[1]  = (m_secs / 60) % 60;
                m_sh[2]  = m_secs % 60;
            end
        end else if (!b[6] || b[5]) begin
            m_edit = 0;
        end else if (b[4]) begin
            m_edit = 0;
            commit = 1;
        end else if (b[3]) begin
            m_sh[m_cur] = (m_sh[m_cur] + 1) % lim[m_cur];
        end else if (b[2]) begin
            m_sh[m_cur] = (m_sh[m_cur] + lim[m_cur] - 1) % lim[m_cur];
        end else if (b[1]) begin
            m_cur = (m_cur + 2) % 3;
        end else if (b[0]) begin
            m_cur = (m_cur + 1) % 3;
        end
        m_carry = 0;
        if (commit) begin
            m_secs = m_sh[0] * 3600 + m_sh[1] * 60 + m_sh[2];
            m_pre  = 0;
        end else begin
            if (tick) begin
                m_carry = (m_secs == 86399);
                m_secs  = (m_secs + 1) % 86400;
            end
            m_pre = (m_pre + 1) % HZ;
        end
    endtask

    task automatic chk(input string nm, input logic [47:0] got,
                       input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic compare_all();
        chk("hour",   48'(hour),      48'(m_secs / 3600));
        chk("minute", 48'(minute),    48'((m_secs / 60) % 60));
        chk("second", 48'(second),    48'(m_secs % 60));
        chk("norm",   48'(norm),      48'(!m_edit));
        chk("carry",  48'(carry_out), 48'(m_carry));
        chk("out",    out,            m_out);
    endtask

    task automatic cycle(input bit r, input logic [6:0] b);
        rst_n = !r;
        {pad.mode, pad.esc, pad.enter, pad.up,
         pad.down, pad.left, pad.right} = b;
        @(posedge clk);
        #1;
        model_step(r, b);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, B_MODE);
    endtask

    initial begin
        cycle(1'b1, B_MODE);
        chk("rst_out",   out,             48'hC0C0C0C0C0C0);
        chk("rst_norm",  48'(norm),       48'd1);
        chk("rst_carry", 48'(carry_out),  48'd0);

        cycle(1'b0, B_MODE | B_ENTER);
        cycle(1'b0, B_MODE | B_DOWN);
        cycle(1'b0, B_MODE | B_RIGHT);
`ifndef BLINK_EN
        chk("edit_digits", 48'(out[47:16]), 48'h2430C0C0);
`endif
        cycle(1'b0, B_MODE | B_DOWN);
        cycle(1'b0, B_MODE | B_RIGHT);
        cycle(1'b0, B_MODE | B_DOWN);
        cycle(1'b0, B_MODE | B_ENTER);
        chk("set_h", 48'(hour),   48'd23);
        chk("set_m", 48'(minute), 48'd59);
        chk("set_s", 48'(second), 48'd59);
        idle(3);
        chk("carry_early", 48'(carry_out), 48'd0);
        idle(1);
        chk("carry_pulse", 48'(carry_out), 48'd1);
        chk("roll_h", 48'(hour),   48'd0);
        chk("roll_m", 48'(minute), 48'd0);
        chk("roll_s", 48'(second), 48'd0);
        idle(1);
        chk("carry_end", 48'(carry_out), 48'd0);

        cycle(1'b0, B_MODE | B_ENTER);
        cycle(1'b0, B_MODE | B_DOWN);
        cycle(1'b0, B_MODE | B_RIGHT);
        cycle(1'b0, B_MODE | B_DOWN);
        cycle(1'b0, B_MODE | B_UP);
        cycle(1'b0, B_MODE | B_ENTER);
        chk("edit_h", 48'(hour),   48'd23);
        chk("edit_m", 48'(minute), 48'd0);

        cycle(1'b0, B_MODE | B_ENTER);
        repeat (3) cycle(1'b0, B_MODE | B_UP);
        cycle(1'b0, B_MODE | B_ESC);
        chk("esc_norm", 48'(norm), 48'd1);
        chk("esc_h",    48'(hour), 48'd23);

        cycle(1'b0, B_MODE | B_ENTER);
        cycle(1'b0, B_MODE | B_UP);
        cycle(1'b0, B_MODE | B_ENTER | B_ESC);
        chk("coll_norm", 48'(norm), 48'd1);
        chk("coll_h",    48'(hour), 48'd23);

        cycle(1'b0, B_MODE | B_ENTER);
        cycle(1'b0, B_MODE | B_UP);
        cycle(1'b0, B_ENTER);
        chk("mdrop_norm", 48'(norm), 48'd1);
        idle(1);
        chk("mdrop_h", 48'(hour), 48'd23);

        cycle(1'b0, B_MODE | B_ENTER);
        cycle(1'b0, B_MODE | B_UP);
        cycle(1'b0, B_MODE | B_RIGHT);
        cycle(1'b1, B_MODE | B_UP);
        chk("rst_edit_h",    48'(hour),   48'd0);
        chk("rst_edit_s",    48'(second), 48'd0);
        chk("rst_edit_norm", 48'(norm),   48'd1);
        idle(1);
        chk("rst_edit_out", out, 48'hC0C0C0C0C0C0);

        cycle(1'b1, B_MODE);
        cycle(1'b0, B_MODE | B_ENTER);
        cycle(1'b0, B_MODE | B_RIGHT);
        cycle(1'b0, B_MODE | B_RIGHT);
        cycle(1'b0, B_MODE | B_UP);
        idle(3);
        cycle(1'b0, B_MODE | B_ENTER);
        chk("tick_commit_s", 48'(second), 48'd1);
        chk("tick_commit_m", 48'(minute), 48'd0);
        idle(3);
        chk("tick_hold_s", 48'(second), 48'd1);
        idle(1);
        chk("tick_next_s", 48'(second), 48'd2);

        for (int i = 0; i < 4000; i++) begin
            logic [6:0] b;
            bit r;
            r = ($urandom_range(0, 499) == 0);
            b = '0;
            b[6] = ($urandom_range(0, 9) != 0);
            for (int j = 0; j < 6; j++)
                b[j] = ($urandom_range(0, 5) == 0);
            cycle(r, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
